rc4_decrypt_message: RTL and testbench
======================================

Name: rc4_decrypt_message

Overview:
- Final RC4 stage (PRGA) that sits after the S-memory init and key-shuffle stages.
- It reads the shuffled S array, performs the per-byte swap, XORs the keystream with the encrypted-message ROM, and writes plaintext to the decrypted-message RAM.
- It flags failure as soon as a decrypted byte is not lowercase ASCII or space, so the core controller can move to the next key.
- It owns the S-memory port only while the controller selects it as the S source.

Parameters:
- MSG_LEN, 32: number of message bytes; must be a power of two, at most 256.
- MSG_AW, 5: message address width; equals log2(MSG_LEN).
- CHECK_ASCII, 1: when 1, an invalid plaintext byte aborts with failed; when 0, validity is never checked.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  reset; asynchronous, active-low
- start  in  1  level request; sampled in IDLE
- finish  out  1  high in DONE and FAIL
- failed  out  1  high only in FAIL
- s_address  out  8  S-memory address
- s_data  out  8  S-memory write data
- s_wren  out  1  S-memory write enable
- s_q  in  8  S-memory read data
- rom_address  out  MSG_AW  encrypted ROM address; always equals k
- rom_q  in  8  encrypted byte
- dec_address  out  MSG_AW  decrypted RAM address
- dec_data  out  8  decrypted byte
- dec_wren  out  1  decrypted RAM write enable

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - i, j, k, si, sj and f are cleared to 0.
  - All outputs are 0.
- Memory timing: all memories have a registered address. Read data is valid in the cycle after the address is driven.
- Output drive rules:
  - Address and data outputs are decoded from state and internal registers.
  - s_wren and dec_wren are high for exactly one cycle per write.
  - Where no S address is listed below, s_address holds 0.
- All i/j/index arithmetic is modulo 256 (8-bit wrap). k is MSG_AW bits.
- State sequence, one cycle per state:
  - IDLE: if start=1, set i=1, j=0, k=0, then go to READ_SI.
  - READ_SI: s_address=i.
  - LATCH_SI: si<=s_q; j<=j+s_q.
  - READ_SJ: s_address=j (the updated j).
  - LATCH_SJ: sj<=s_q.
  - WRITE_SI: s_address=i, s_data=sj, s_wren=1.
  - WRITE_SJ: s_address=j, s_data=si, s_wren=1.
  - READ_F: s_address=si+sj.
  - LATCH_F: f<=s_q.
  - WRITE_DEC: dec_address=k, dec_data=f^rom_q, dec_wren=1. Register bad=1 if CHECK_ASCII and the byte is neither 8'h20 nor in 8'h61..8'h7A.
  - NEXT: if bad, go to FAIL. Else if k==MSG_LEN-1, go to DONE. Else k<=k+1, i<=i+1, go to READ_SI.
  - DONE: finish=1. When start=0, go to IDLE.
  - FAIL: finish=1, failed=1. When start=0, go to IDLE.
- Latency: 10 cycles per byte. finish rises exactly 10*MSG_LEN cycles after start is sampled in IDLE (320 for the default).
- Boundary conditions:
  - i==j: both writes hit the same address, the last write (si) wins, and S is unchanged. This is correct RC4 behaviour.
  - The offending byte is written to the decrypted RAM before abort; no later bytes are written.
  - k wraps only through the DONE path; i wraps 255→0 naturally.
  - start held high in DONE/FAIL keeps the block there; it does not auto-restart.
  - Reset mid-operation aborts immediately with no further memory writes. S and the decrypted RAM contents are left as they were.
- No S writes occur outside WRITE_SI and WRITE_SJ.

Decomposition:
- Shared package ksa_pkg holds:
  - the state enum for this block;
  - ASCII_SPACE=8'h20, ASCII_LOWER_A=8'h61, ASCII_LOWER_Z=8'h7A;
  - S_DEPTH=256.
- One natural sub-module: message_char_check. It is combinational: 8-bit byte in, valid out, using the package constants. The same checker is reused by any later key-search display logic.

Test Plan:
- Identity S (S[x]=x), enc[0]=8'h63, enc[1]=8'h25, remaining bytes chosen to decrypt to 8'h61 → dec[0]=8'h61, dec[1]=8'h20. After byte 1, S[2]=3 and S[3]=2. finish rises 320 cycles after start; failed=0.
- Identity S, enc[0]=8'h00 → dec[0]=8'h02 written and failed=finish=1 after 10 cycles. No dec_wren for address 1. S writes occur only at address 1 (twice).
- Same as the first scenario with CHECK_ASCII=0 and enc[0]=8'h00 → all 32 bytes written; finish=1, failed=0 at cycle 320.
- reset_n pulsed low at cycle 57 mid-message → outputs 0 immediately and state IDLE. With start high after release, the sequence restarts with i=1, j=0, k=0.
- Handshake: start held low → no wren ever. Start held high through DONE → stays DONE. Start dropped → IDLE next cycle; start raised again → new run completes in another 320 cycles.
- Randomized S permutation plus random enc compared against a software RC4 PRGA model over 32 bytes → dec RAM and final S match bit-exactly.

Source files
------------

// File: rtl/ksa_pkg.sv
// Shared definitions for the RC4 key-search datapath: PRGA state encoding,
// plaintext character limits and S-memory depth.
package ksa_pkg;

  localparam int S_DEPTH = 256;

  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_READ_SI,
    ST_LATCH_SI,
    ST_READ_SJ,
    ST_LATCH_SJ,
    ST_WRITE_SI,
    ST_WRITE_SJ,
    ST_READ_F,
    ST_LATCH_F,
    ST_WRITE_DEC,
    ST_NEXT,
    ST_DONE,
    ST_FAIL
  } rc4_state_e;

endpackage

// File: rtl/message_char_check.sv
// Combinational plaintext filter: a byte is acceptable when it is a space
// or a lowercase ASCII letter.
module message_char_check
  import ksa_pkg::*;
(
  input  logic [7:0] i_char,
  output logic       o_valid
);

  assign o_valid = (i_char == ASCII_SPACE) ||
                   ((i_char >= ASCII_LOWER_A) && (i_char <= ASCII_LOWER_Z));

endmodule

// File: rtl/rc4_decrypt_message.sv
// RC4 PRGA stage: swaps S entries per byte, XORs the keystream with the
// encrypted ROM, writes plaintext and aborts on the first non-text byte.
module rc4_decrypt_message
  import ksa_pkg::*;
#(
  parameter int MSG_LEN     = 32,
  parameter int MSG_AW      = 5,
  parameter bit CHECK_ASCII = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              finish,
  output logic              failed,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_wren
);

  rc4_state_e        r_state;
  logic [7:0]        r_i;
  logic [7:0]        r_j;
  logic [MSG_AW-1:0] r_k;
  logic [7:0]        r_si;
  logic [7:0]        r_sj;
  logic [7:0]        r_f;
  logic              r_bad;

  logic [7:0]        w_plain;
  logic              w_valid;

  assign w_plain = r_f ^ rom_q;

  message_char_check u_char_check (
    .i_char  (w_plain),
    .o_valid (w_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_f     <= '0;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_i     <= 8'd1;
            r_j     <= 8'd0;
            r_k     <= '0;
            r_bad   <= 1'b0;
            r_state <= ST_READ_SI;
          end
        end
        ST_READ_SI:  r_state <= ST_LATCH_SI;
        ST_LATCH_SI: begin
          r_si    <= s_q;
          r_j     <= r_j + s_q;
          r_state <= ST_READ_SJ;
        end
        ST_READ_SJ:  r_state <= ST_LATCH_SJ;
        ST_LATCH_SJ: begin
          r_sj    <= s_q;
          r_state <= ST_WRITE_SI;
        end
        ST_WRITE_SI: r_state <= ST_WRITE_SJ;
        ST_WRITE_SJ: r_state <= ST_READ_F;
        ST_READ_F:   r_state <= ST_LATCH_F;
        ST_LATCH_F: begin
          r_f     <= s_q;
          r_state <= ST_WRITE_DEC;
        end
        ST_WRITE_DEC: begin
          r_bad   <= CHECK_ASCII && !w_valid;
          r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_bad) begin
            r_state <= ST_FAIL;
          end else if (r_k == MSG_AW'(MSG_LEN - 1)) begin
            r_state <= ST_DONE;
          end else begin
            r_k     <= r_k + MSG_AW'(1);
            r_i     <= r_i + 8'd1;
            r_state <= ST_READ_SI;
          end
        end
        // Level handshake: stay put until the controller drops start.
        ST_DONE, ST_FAIL: begin
          if (!start) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_address   = 8'd0;
    s_data      = 8'd0;
    s_wren      = 1'b0;
    dec_address = '0;
    dec_data    = 8'd0;
    dec_wren    = 1'b0;
    case (r_state)
      ST_READ_SI:  s_address = r_i;
      ST_READ_SJ:  s_address = r_j;
      ST_WRITE_SI: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
      end
      ST_WRITE_SJ: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
      end
      ST_READ_F:   s_address = r_si + r_sj;
      ST_WRITE_DEC: begin
        dec_address = r_k;
        dec_data    = w_plain;
        dec_wren    = 1'b1;
      end
      default: ;
    endcase
  end

  assign rom_address = r_k;
  assign finish      = (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign failed      = (r_state == ST_FAIL);

endmodule

// File: tb/tb_rc4_decrypt_message.sv
// Bench for rc4_decrypt_message: two instances (text check on / off) share
// one stimulus; results are compared against a software RC4 PRGA model.
module tb_rc4_decrypt_message;

  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic ld;

  logic [7:0] s_init [256];
  logic [7:0] enc [32];
  logic [7:0] m_s [256];
  logic [7:0] m_ks [32];

  logic       fin [2];
  logic       fl [2];
  logic [7:0] sa [2];
  logic [4:0] ra [2];
  logic       out_or [2];
  int         swc [2];
  int         swo [2];
  int         dwc [2];

  int chk_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic [7:0] s_address, s_data, s_q, rom_q, dec_data;
      logic       s_wren, dec_wren, finish, failed;
      logic [4:0] rom_address, dec_address;
      logic [7:0] s_mem [256];
      logic [7:0] dec_mem [32];
      logic [7:0] s_addr_r;
      logic [4:0] rom_addr_r;
      int         s_wr_cnt, s_wr_other, dec_wr_cnt;

      rc4_decrypt_message #(
        .MSG_LEN     (32),
        .MSG_AW      (5),
        .CHECK_ASCII (gi == 0)
      ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .finish      (finish),
        .failed      (failed),
        .s_address   (s_address),
        .s_data      (s_data),
        .s_wren      (s_wren),
        .s_q         (s_q),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .dec_address (dec_address),
        .dec_data    (dec_data),
        .dec_wren    (dec_wren)
      );

      always @(posedge clk) begin
        s_addr_r   <= s_address;
        rom_addr_r <= rom_address;
        if (ld) begin
          s_mem <= s_init;
          for (int a = 0; a < 32; a++) dec_mem[a] <= 8'hEE;
          s_wr_cnt   <= 0;
          s_wr_other <= 0;
          dec_wr_cnt <= 0;
        end else begin
          if (s_wren) begin
            s_mem[s_address] <= s_data;
            s_wr_cnt <= s_wr_cnt + 1;
            if (s_address != 8'd1) s_wr_other <= s_wr_other + 1;
          end
          if (dec_wren) begin
            dec_mem[dec_address] <= dec_data;
            dec_wr_cnt <= dec_wr_cnt + 1;
          end
        end
      end

      assign s_q        = s_mem[s_addr_r];
      assign rom_q      = enc[rom_addr_r];
      assign fin[gi]    = finish;
      assign fl[gi]     = failed;
      assign sa[gi]     = s_address;
      assign ra[gi]     = rom_address;
      assign swc[gi]    = s_wr_cnt;
      assign swo[gi]    = s_wr_other;
      assign dwc[gi]    = dec_wr_cnt;
      assign out_or[gi] = |{s_address, s_data, s_wren, rom_address, dec_address,
                            dec_data, dec_wren, finish, failed};
    end
  endgenerate

  function automatic logic [7:0] get_dec(input int g, input int a);
    if (g == 0) return g_dut[0].dec_mem[a[4:0]];
    return g_dut[1].dec_mem[a[4:0]];
  endfunction

  function automatic logic [7:0] get_s(input int g, input int a);
    if (g == 0) return g_dut[0].s_mem[a[7:0]];
    return g_dut[1].s_mem[a[7:0]];
  endfunction

  function automatic bit is_text(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    chk_cnt++;
    if (act != exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
    end
  endtask

  // Textbook RC4 PRGA over nb bytes starting from s_init.
  task automatic prga(input int nb);
    int i, j;
    logic [7:0] t;
    for (int a = 0; a < 256; a++) m_s[a] = s_init[a];
    i = 0;
    j = 0;
    for (int n = 0; n < nb; n++) begin
      i = (i + 1) % 256;
      j = (j + int'(m_s[i])) % 256;
      t = m_s[i];
      m_s[i] = m_s[j];
      m_s[j] = t;
      m_ks[n] = m_s[(int'(m_s[i]) + int'(m_s[j])) % 256];
    end
  endtask

  task automatic load_mems();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic run_case(input string nm, output int lat0_o, output int fail0_o);
    logic [7:0] s32 [256];
    int first, n0, bad0, bad1, lat0, lat1, f0;
    logic [7:0] e;
    prga(32);
    for (int a = 0; a < 256; a++) s32[a] = m_s[a];
    first = -1;
    for (int n = 0; n < 32; n++)
      if (first < 0 && !is_text(enc[n] ^ m_ks[n])) first = n;
    n0 = (first < 0) ? 32 : first + 1;
    prga(n0);
    load_mems();
    start = 1'b1;
    lat0 = -1;
    lat1 = -1;
    f0 = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        check({nm, "_first_s_addr"}, int'(sa[0]), 1);
        check({nm, "_first_rom_addr"}, int'(ra[0]), 0);
      end
      if (fin[0] && lat0 < 0) begin
        lat0 = n - 1;
        f0 = int'(fl[0]);
      end
      if (fin[1] && lat1 < 0) lat1 = n - 1;
      if (lat0 >= 0 && lat1 >= 0) break;
    end
    check({nm, "_latency_chk"}, lat0, 10 * n0);
    check({nm, "_latency_nochk"}, lat1, 320);
    check({nm, "_failed_chk"}, f0, (first >= 0) ? 1 : 0);
    check({nm, "_failed_nochk"}, int'(fl[1]), 0);
    check({nm, "_dec_writes_chk"}, dwc[0], n0);
    check({nm, "_dec_writes_nochk"}, dwc[1], 32);
    bad0 = 0;
    bad1 = 0;
    for (int a = 0; a < 32; a++) begin
      e = (a < n0) ? (enc[a] ^ m_ks[a]) : 8'hEE;
      if (get_dec(0, a) !== e) bad0++;
      if (get_dec(1, a) !== (enc[a] ^ m_ks[a])) bad1++;
    end
    check({nm, "_dec_ram_mismatch_chk"}, bad0, 0);
    check({nm, "_dec_ram_mismatch_nochk"}, bad1, 0);
    bad0 = 0;
    bad1 = 0;
    for (int a = 0; a < 256; a++) begin
      if (get_s(0, a) !== m_s[a]) bad0++;
      if (get_s(1, a) !== s32[a]) bad1++;
    end
    check({nm, "_s_mismatch_chk"}, bad0, 0);
    check({nm, "_s_mismatch_nochk"}, bad1, 0);
    repeat (5) @(posedge clk);
    #1;
    check({nm, "_hold_finish"}, int'(fin[0]) + int'(fin[1]), 2);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({nm, "_release_finish"}, int'(fin[0]) + int'(fin[1]), 0);
    repeat (2) @(negedge clk);
    lat0_o = lat0;
    fail0_o = f0;
  endtask

  typedef struct {
    logic [7:0] enc0;
    logic [7:0] enc1;
    logic [7:0] dec0;
    logic [7:0] dec1;
    int         fail;
    int         lat;
  } vec_t;

  initial begin
    vec_t vecs [7];
    int lat, fres, c0, r;
    logic [7:0] t;
    string nm;

    vecs[0] = '{8'h63, 8'h25, 8'h61, 8'h20, 0, 320};
    vecs[1] = '{8'h00, 8'h25, 8'h02, 8'h20, 1, 10};
    vecs[2] = '{8'h63, 8'h00, 8'h61, 8'h05, 1, 20};
    vecs[3] = '{8'h22, 8'h7f, 8'h20, 8'h7a, 0, 320};
    vecs[4] = '{8'h62, 8'h25, 8'h60, 8'h20, 1, 10};
    vecs[5] = '{8'h79, 8'h25, 8'h7b, 8'h20, 1, 10};
    vecs[6] = '{8'h78, 8'h64, 8'h7a, 8'h61, 0, 320};

    reset_n = 1'b0;
    start = 1'b0;
    ld = 1'b0;
    for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
    for (int n = 0; n < 32; n++) enc[n] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs_chk", int'(out_or[0]), 0);
    check("reset_outputs_nochk", int'(out_or[1]), 0);
    load_mems();
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_writes", swc[0] + dwc[0] + swc[1] + dwc[1], 0);
    check("idle_no_finish", int'(fin[0]) + int'(fin[1]), 0);

    // Identity S with directed first two bytes; the rest decrypt to 'a'.
    for (int v = 0; v < 7; v++) begin
      nm = $sformatf("vec%0d", v);
      for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
      prga(32);
      for (int n = 2; n < 32; n++) enc[n] = m_ks[n] ^ 8'h61;
      enc[0] = vecs[v].enc0;
      enc[1] = vecs[v].enc1;
      run_case(nm, lat, fres);
      check({nm, "_tbl_dec0"}, int'(get_dec(1, 0)), int'(vecs[v].dec0));
      check({nm, "_tbl_dec1"}, int'(get_dec(1, 1)), int'(vecs[v].dec1));
      check({nm, "_tbl_failed"}, fres, vecs[v].fail);
      check({nm, "_tbl_latency"}, lat, vecs[v].lat);
      if (vecs[v].lat == 10) begin
        check({nm, "_s_write_count"}, swc[0], 2);
        check({nm, "_s_write_off_addr1"}, swo[0], 0);
      end
      if (v == 0) begin
        check({nm, "_s2_after_run_nochk_ne_ident"}, int'(get_s(1, 2) != 8'd2 || get_s(1, 3) != 8'd3), 1);
      end
    end

    // Random permutation of S; even runs use random ciphertext, odd runs
    // ciphertext that decrypts to text so the checking instance completes.
    for (int it = 0; it < 4; it++) begin
      nm = $sformatf("rand%0d", it);
      for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
      for (int a = 255; a > 0; a--) begin
        r = int'($urandom_range(a, 0));
        t = s_init[a];
        s_init[a] = s_init[r];
        s_init[r] = t;
      end
      prga(32);
      for (int n = 0; n < 32; n++) begin
        if (it % 2 == 0) begin
          enc[n] = 8'($urandom());
        end else begin
          r = int'($urandom_range(26, 0));
          enc[n] = m_ks[n] ^ ((r == 26) ? 8'h20 : (8'h61 + 8'(r)));
        end
      end
      run_case(nm, lat, fres);
    end

    // Reset mid-message, then restart with start still high.
    for (int a = 0; a < 256; a++) s_init[a] = a[7:0];
    prga(32);
    for (int n = 0; n < 32; n++) enc[n] = m_ks[n] ^ 8'h61;
    load_mems();
    start = 1'b1;
    repeat (57) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_outputs_chk", int'(out_or[0]), 0);
    check("midreset_outputs_nochk", int'(out_or[1]), 0);
    c0 = swc[0] + dwc[0] + swc[1] + dwc[1];
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_writes", swc[0] + dwc[0] + swc[1] + dwc[1], c0);
    check("midreset_outputs_held", int'(out_or[0]) + int'(out_or[1]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_s_addr_i1", int'(sa[0]), 1);
    check("restart_rom_addr_k0", int'(ra[0]), 0);
    lat = -1;
    for (int n = 2; n <= 400; n++) begin
      @(posedge clk);
      #1;
      if (fin[1]) begin
        lat = n - 1;
        break;
      end
    end
    check("restart_latency", lat, 320);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule
